// File: rtl/vlsu_beat_seq.sv
// Vector load/store beat sequencer: splits a SEW=8 register image into
// 32-bit memory beats and assembles load beats into one VRF write-back.
module vlsu_beat_seq #(
  parameter int VLEN_BITS = 128,
  parameter int MEM_W     = 32,
  parameter int BEATS     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_is_store_i,
  input  logic [31:0]            req_base_addr_i,
  input  logic [6:0]             req_vl_i,
  input  logic [4:0]             req_vd_addr_i,
  input  logic [VLEN_BITS-1:0]   req_vs3_data_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [MEM_W-1:0]       mem_wdata_o,
  output logic [MEM_W/8-1:0]     mem_wstrb_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [MEM_W-1:0]       mem_rdata_i,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_vd_addr_o,
  output logic [VLEN_BITS-1:0]   wb_data_o,
  output logic [1:0]             wb_src_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   hold_o
);

  localparam int VLENB = VLEN_BITS / 8;
  localparam int BW    = $clog2(BEATS);
  localparam int LW    = $clog2(VLENB) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_R,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_is_store;
  logic                   r_err;
  logic                   r_wb;
  logic [31:0]            r_base;
  logic [LW-1:0]          r_len;
  logic [BW:0]            r_nbeats;
  logic [BW-1:0]          r_beat;
  logic [4:0]             r_vd;
  logic [VLEN_BITS-1:0]   r_sdata;
  logic [VLEN_BITS-1:0]   r_lbuf;
  logic [VLEN_BITS-1:0]   r_wb_data;
  logic [4:0]             r_wb_vd;

  logic                   w_hs;
  logic                   w_mis;
  logic [LW-1:0]          w_len;
  logic [LW:0]            w_lp3;
  logic [BW:0]            w_nbeats;
  logic                   w_last;
  logic [LW-1:0]          w_rem;
  logic [3:0]             w_strb;
  logic [6:0]             w_boff;
  logic [VLEN_BITS-1:0]   w_lbuf_nxt;

  assign w_hs     = req_valid_i && (r_state == S_IDLE);
  assign w_mis    = |req_base_addr_i[1:0];
  assign w_len    = (req_vl_i > 7'(VLENB)) ? LW'(VLENB)
                                           : req_vl_i[LW-1:0];
  assign w_lp3    = {1'b0, w_len} + (LW+1)'(3);
  assign w_nbeats = w_lp3[BW+2:2];
  assign w_last   = ({1'b0, r_beat} == (r_nbeats - 1'b1));
  assign w_rem    = r_len - LW'({r_beat, 2'b00});
  assign w_boff   = 7'({r_beat, 5'b00000});

  // Bytes past the effective length are masked on both stores and loads.
  always_comb begin
    w_strb = 4'h0;
    if (w_rem >= LW'(4)) begin
      w_strb = 4'hF;
    end else begin
      unique case (w_rem[1:0])
        2'd0:    w_strb = 4'h0;
        2'd1:    w_strb = 4'h1;
        2'd2:    w_strb = 4'h3;
        default: w_strb = 4'h7;
      endcase
    end
  end

  always_comb begin
    w_lbuf_nxt = r_lbuf;
    for (int k = 0; k < 4; k++) begin
      if (w_strb[k])
        w_lbuf_nxt[w_boff + 7'(8*k) +: 8] = mem_rdata_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_err      <= 1'b0;
      r_wb       <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_nbeats   <= '0;
      r_beat     <= '0;
      r_vd       <= '0;
      r_sdata    <= '0;
      r_lbuf     <= '0;
      r_wb_data  <= '0;
      r_wb_vd    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_is_store <= req_is_store_i;
            r_base     <= req_base_addr_i;
            r_len      <= w_len;
            r_nbeats   <= w_nbeats;
            r_vd       <= req_vd_addr_i;
            r_sdata    <= req_vs3_data_i;
            r_err      <= w_mis;
            r_wb       <= !req_is_store_i && !w_mis && (w_len != '0);
            r_beat     <= '0;
            r_lbuf     <= '0;
            if (w_mis || (w_len == '0))
              r_state <= S_DONE;
            else
              r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_gnt_i) begin
            if (!r_is_store) begin
              r_state <= S_WAIT_R;
            end else if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_WAIT_R: begin
          if (mem_rvalid_i) begin
            r_lbuf <= w_lbuf_nxt;
            if (w_last) begin
              r_wb_data <= w_lbuf_nxt;
              r_wb_vd   <= r_vd;
              r_state   <= S_DONE;
            end else begin
              r_beat  <= r_beat + 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = (r_state == S_IDLE);
  assign hold_o       = (r_state != S_IDLE);
  assign mem_req_o    = (r_state == S_ISSUE);
  assign mem_we_o     = r_is_store;
  assign mem_addr_o   = r_base + 32'({r_beat, 2'b00});
  assign mem_wdata_o  = r_sdata[w_boff +: MEM_W];
  assign mem_wstrb_o  = w_strb;
  assign done_o       = (r_state == S_DONE);
  assign err_o        = (r_state == S_DONE) && r_err;
  assign wb_valid_o   = (r_state == S_DONE) && r_wb;
  assign wb_vd_addr_o = r_wb_vd;
  assign wb_data_o    = r_wb_data;
  assign wb_src_o     = 2'b00;

endmodule

// File: tb/tb_vlsu_beat_seq.sv
// Bench for vlsu_beat_seq: directed cases plus randomized operations
// against a byte-level reference model with per-cycle output checks.
module tb_vlsu_beat_seq;

  logic         clk;
  logic         rst_n;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_is_store_i;
  logic [31:0]  req_base_addr_i;
  logic [6:0]   req_vl_i;
  logic [4:0]   req_vd_addr_i;
  logic [127:0] req_vs3_data_i;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic [3:0]   mem_wstrb_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic         wb_valid_o;
  logic [4:0]   wb_vd_addr_o;
  logic [127:0] wb_data_o;
  logic [1:0]   wb_src_o;
  logic         done_o;
  logic         err_o;
  logic         hold_o;

  vlsu_beat_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_is_store_i  (req_is_store_i),
    .req_base_addr_i (req_base_addr_i),
    .req_vl_i        (req_vl_i),
    .req_vd_addr_i   (req_vd_addr_i),
    .req_vs3_data_i  (req_vs3_data_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wstrb_o     (mem_wstrb_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .wb_valid_o      (wb_valid_o),
    .wb_vd_addr_o    (wb_vd_addr_o),
    .wb_data_o       (wb_data_o),
    .wb_src_o        (wb_src_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .hold_o          (hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int           g_gd [4];
  int           g_rd [4];
  logic [127:0] last_wb;
  int           last_done_cyc;
  int           last_nbeats;
  logic [3:0]   last_strb [4];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ready"}, req_ready_o, 1);
    chk({tag, ".hold"}, hold_o, 0);
    chk({tag, ".mem_req"}, mem_req_o, 0);
    chk({tag, ".mem_we"}, mem_we_o, 0);
    chk({tag, ".mem_addr"}, mem_addr_o, 0);
    chk({tag, ".mem_wdata"}, mem_wdata_o, 0);
    chk({tag, ".mem_wstrb"}, mem_wstrb_o, 0);
    chk({tag, ".wb_valid"}, wb_valid_o, 0);
    chk({tag, ".wb_vd"}, wb_vd_addr_o, 0);
    chk({tag, ".wb_data"}, wb_data_o, 0);
    chk({tag, ".wb_src"}, wb_src_o, 0);
    chk({tag, ".done"}, done_o, 0);
    chk({tag, ".err"}, err_o, 0);
  endtask

  task automatic zero_delays();
    for (int i = 0; i < 4; i++) begin
      g_gd[i] = 0;
      g_rd[i] = 0;
    end
  endtask

  // Runs one operation as vid and memory; the model is byte arithmetic:
  // byte i of the image is live iff i < min(vl,16), beat b covers 4b..4b+3.
  task automatic run_op(input bit st, input logic [31:0] base,
                        input logic [6:0] vl, input logic [4:0] vd,
                        input logic [127:0] data, input bit addr_rd);
    int len;
    int nb;
    int cyc;
    bit mis;
    bit exp_wb;
    logic [127:0] img;
    logic [31:0]  rword;
    logic [31:0]  eaddr;
    logic [3:0]   estrb;
    len    = (vl > 16) ? 16 : int'(vl);
    mis    = (base[1:0] != 2'b00);
    nb     = mis ? 0 : (len + 3) / 4;
    exp_wb = !st && !mis && (len > 0);
    img    = '0;
    @(negedge clk);
    req_valid_i     = 1'b1;
    req_is_store_i  = st;
    req_base_addr_i = base;
    req_vl_i        = vl;
    req_vd_addr_i   = vd;
    req_vs3_data_i  = data;
    chk("hs.ready", req_ready_o, 1);
    chk("hs.hold", hold_o, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid_i     = 1'b0;
    req_is_store_i  = 1'($urandom);
    req_base_addr_i = $urandom;
    req_vl_i        = 7'($urandom);
    req_vd_addr_i   = 5'($urandom);
    req_vs3_data_i  = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    last_nbeats = 0;
    for (int b = 0; b < nb; b++) begin
      eaddr = base + 32'(4 * b);
      for (int k = 0; k < 4; k++) estrb[k] = ((4 * b + k) < len);
      for (int s = 0; s <= g_gd[b]; s++) begin
        chk("iss.mem_req", mem_req_o, 1);
        chk("iss.done", done_o, 0);
        chk("iss.hold", hold_o, 1);
        chk("iss.ready", req_ready_o, 0);
        chk("iss.addr", mem_addr_o, eaddr);
        chk("iss.we", mem_we_o, st);
        chk("iss.strb", mem_wstrb_o, estrb);
        if (st) chk("iss.wdata", mem_wdata_o, data[32 * b +: 32]);
        last_strb[b] = estrb;
        mem_gnt_i    = (s == g_gd[b]);
        mem_rvalid_i = 1'($urandom);
        mem_rdata_i  = $urandom;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
      end
      last_nbeats++;
      if (!st) begin
        for (int s = 0; s <= g_rd[b]; s++) begin
          chk("wr.mem_req", mem_req_o, 0);
          chk("wr.done", done_o, 0);
          chk("wr.hold", hold_o, 1);
          mem_gnt_i = 1'($urandom);
          if (s == g_rd[b]) begin
            rword        = addr_rd ? eaddr : $urandom;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rword;
            for (int k = 0; k < 4; k++)
              if ((4 * b + k) < len) img[8 * (4 * b + k) +: 8] = rword[8 * k +: 8];
          end
          @(posedge clk);
          @(negedge clk);
          cyc++;
          mem_gnt_i    = 1'b0;
          mem_rvalid_i = 1'b0;
        end
      end
    end
    chk("dn.done", done_o, 1);
    chk("dn.err", err_o, mis);
    chk("dn.wb_valid", wb_valid_o, exp_wb);
    chk("dn.mem_req", mem_req_o, 0);
    chk("dn.hold", hold_o, 1);
    chk("dn.ready", req_ready_o, 0);
    chk("dn.wb_src", wb_src_o, 0);
    if (exp_wb) begin
      chk("dn.wb_data", wb_data_o, img);
      chk("dn.wb_vd", wb_vd_addr_o, vd);
    end
    last_done_cyc = cyc;
    last_wb = img;
    @(posedge clk);
    @(negedge clk);
    chk("post.ready", req_ready_o, 1);
    chk("post.hold", hold_o, 0);
    chk("post.done", done_o, 0);
    chk("post.err", err_o, 0);
    chk("post.wb_valid", wb_valid_o, 0);
    if (exp_wb) chk("post.wb_hold", wb_data_o, img);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    req_valid_i     = 1'b1;
    req_is_store_i  = 1'b0;
    req_base_addr_i = 32'h0000_2000;
    req_vl_i        = 7'd16;
    req_vd_addr_i   = 5'd3;
    req_vs3_data_i  = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk("rst.iss_req", mem_req_o, 1);
      mem_gnt_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_gnt_i = 1'b0;
      if (b < 2) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
      end
    end
    chk("rst.wait_req", mem_req_o, 0);
    chk("rst.wait_hold", hold_o, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst.async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    chk("stray.wb_valid", wb_valid_o, 0);
    chk("stray.done", done_o, 0);
    chk("stray.ready", req_ready_o, 1);
    chk("stray.hold", hold_o, 0);
    chk("stray.wb_data", wb_data_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    logic [6:0]  vl;
    int          mode;
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    req_is_store_i = 1'b0;
    req_base_addr_i = '0;
    req_vl_i = '0;
    req_vd_addr_i = '0;
    req_vs3_data_i = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    #12 check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    zero_delays();
    run_op(1'b0, 32'h0000_1000, 7'd16, 5'd7, '0, 1'b1);
    chk("lit.load16_cyc", last_done_cyc, 9);
    chk("lit.load16_img", last_wb,
        128'h0000100C_00001008_00001004_00001000);

    zero_delays();
    run_op(1'b1, 32'h0000_0020, 7'd6, 5'd1,
           128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0);
    chk("lit.st6_cyc", last_done_cyc, 3);
    chk("lit.st6_beats", last_nbeats, 2);
    chk("lit.st6_strb0", last_strb[0], 4'hF);
    chk("lit.st6_strb1", last_strb[1], 4'h3);

    zero_delays();
    g_gd[0] = 3;
    run_op(1'b0, 32'h0000_0300, 7'd5, 5'd9, '0, 1'b1);
    chk("lit.ld5_cyc", last_done_cyc, 8);
    chk("lit.ld5_img", last_wb, 128'h04_0000_0300);

    zero_delays();
    run_op(1'b0, 32'h0000_1002, 7'd16, 5'd2, '0, 1'b0);
    chk("lit.mis_cyc", last_done_cyc, 1);
    chk("lit.mis_beats", last_nbeats, 0);

    run_op(1'b0, 32'h0000_0400, 7'd0, 5'd4, '0, 1'b0);
    chk("lit.vl0_cyc", last_done_cyc, 1);

    run_op(1'b1, 32'h0000_0500, 7'd100, 5'd4,
           {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    chk("lit.vl100_beats", last_nbeats, 4);
    chk("lit.vl100_cyc", last_done_cyc, 5);

    reset_mid_op();
    zero_delays();
    run_op(1'b0, 32'h0000_3000, 7'd16, 5'd11, '0, 1'b1);
    chk("lit.after_rst_cyc", last_done_cyc, 9);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 7);
      if (mode == 0) begin
        base = $urandom;
        if (base[1:0] == 2'b00) base[0] = 1'b1;
      end else if (mode == 1) begin
        base = 32'hFFFF_FFF8;
      end else begin
        base = $urandom & 32'hFFFF_FFFC;
      end
      vl = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                       : 7'($urandom_range(0, 20));
      for (int i = 0; i < 4; i++) begin
        g_gd[i] = $urandom_range(0, 2);
        g_rd[i] = $urandom_range(0, 2);
      end
      run_op(1'($urandom), base, vl, 5'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vlsu_beat_seq.md
# vlsu_beat_seq

Vector load/store beat sequencer for the RVV core. It accepts one unit-stride SEW=8 vector memory operation from the decode stage (vid) and splits the 128-bit (VLENB = 16 byte) register image into 32-bit memory beats. For loads it assembles the returned beats and delivers a single write-back to the vector register file with source VREG_WB_SRC_MEMORY. It asserts the VLSU hold request toward ctrl while busy.

## Interface
- VLEN_BITS, 128, vector register width in bits
- MEM_W, 32, memory data bus width in bits
- BEATS, 4, maximum beats per operation (VLEN_BITS/MEM_W)

- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  vid presents an operation
- req_ready_o  out  1  sequencer can accept; high only in IDLE
- req_is_store_i  in  1  1 = store, 0 = load
- req_base_addr_i  in  32  byte base address
- req_vl_i  in  7  element count (bytes at SEW=8)
- req_vd_addr_i  in  5  destination register for loads
- req_vs3_data_i  in  128  store data; byte k sits at bits [8k+7:8k]
- mem_req_o  out  1  beat request
- mem_we_o  out  1  write enable
- mem_addr_o  out  32  beat address
- mem_wdata_o  out  32  store beat data
- mem_wstrb_o  out  4  byte strobes
- mem_gnt_i  in  1  beat accepted
- mem_rvalid_i  in  1  load data valid
- mem_rdata_i  in  32  load data
- wb_valid_o  out  1  one-cycle VRF write pulse (loads only)
- wb_vd_addr_o  out  5  VRF write address
- wb_data_o  out  128  assembled register image
- wb_src_o  out  2  constant 2'b00 (VREG_WB_SRC_MEMORY)
- done_o  out  1  one-cycle completion pulse (loads and stores)
- err_o  out  1  one-cycle misalignment pulse
- hold_o  out  1  hold request to ctrl (drives HOLD_VLSU_BIT); high in all states except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_R, DONE.
- **IDLE**
  - Handshake occurs on req_valid_i && req_ready_o.
  - On handshake, latch all request fields.
  - Effective length: len = min(req_vl_i, 16). Beat count: nbeats = ceil(len/4).
- **Request outcomes on handshake**
  - If req_base_addr_i[1:0] != 0: go to DONE with err flagged. No memory traffic, no wb_valid_o.
  - Else if len == 0: go to DONE. No memory traffic, no wb_valid_o.
  - Else: clear the load buffer to zero, set beat = 0, go to ISSUE.
- **ISSUE**
  - mem_req_o = 1, mem_we_o = is_store, mem_addr_o = base + 4*beat (32-bit wrap).
  - mem_wdata_o = store bytes [4*beat+3 : 4*beat].
  - mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o stay stable until mem_gnt_i.
  - Strobes: rem = len - 4*beat. mem_wstrb_o = 4'b1111 if rem >= 4, else (1<<rem)-1. Loads drive the same strobe pattern.
  - On gnt, store: if beat == nbeats-1 go to DONE; else beat++ and stay in ISSUE.
  - On gnt, load: go to WAIT_R.
- **WAIT_R**
  - mem_req_o = 0.
  - On mem_rvalid_i, write the rdata bytes whose strobe bit is set into buffer bytes [4*beat+3 : 4*beat]. Unstrobed bytes stay zero, so the tail is zero-filled.
  - Then: if last beat go to DONE; else beat++ and go to ISSUE.
- **DONE** (exactly one cycle, then IDLE)
  - done_o = 1.
  - err_o = 1 if the request was misaligned.
  - wb_valid_o = 1 only for an aligned load with len > 0.
  - wb_data_o and wb_vd_addr_o are valid during wb_valid_o and hold their value afterwards.
- **Ignored inputs**
  - mem_rvalid_i outside WAIT_R is ignored. The memory returns rvalid no earlier than the cycle after gnt.
  - mem_gnt_i outside ISSUE is ignored.

## Timing
- **Reset values:** state = IDLE.
  - req_ready_o = 1, hold_o = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, mem_wstrb_o = 0.
  - wb_valid_o = 0, wb_vd_addr_o = 0, wb_data_o = 0, wb_src_o = 0.
  - done_o = 0, err_o = 0.
- **Reset mid-operation:** assertion of rst_n = 0 drops mem_req_o immediately (asynchronously). No partial write-back is produced. Any outstanding rvalid after release is ignored, because the FSM is in IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from mem_* inputs to mem_* outputs.
- **Handshake cycle:** cycle 0 is the handshake edge. ISSUE starts in cycle 1.
- **Store latency:** with gnt in every ISSUE cycle, a 16-byte store issues beats in cycles 1–4. done_o fires in cycle 5.
- **Load latency:** with gnt on the first ISSUE cycle and rvalid on the next cycle, each beat takes 2 cycles. A 16-byte load fires wb_valid_o/done_o in cycle 9.
- **Stalls:** each cycle of gnt or rvalid delay adds one cycle.
- **Back-to-back requests:** req_ready_o returns high in the cycle after DONE. The minimum spacing between handshakes is therefore 2 cycles plus the beat time.

## Test plan
- Aligned load, base 0x1000, vl 16, gnt and rvalid immediate, rdata = address -> addresses 0x1000/04/08/0C; wb_data_o = {32'h100C, 32'h1008, 32'h1004, 32'h1000}; wb_valid_o in cycle 9.
- Store, vl 6, base 0x20 -> two beats; strobes 1111 then 0011; done_o in cycle 3; no wb_valid_o.
- Load, vl 5, gnt delayed 3 cycles on beat 0 -> address/strobe held stable throughout the delay; wb_data_o bytes 5–15 are zero.
- Misaligned base 0x1002 -> no mem_req_o; err_o and done_o pulse in cycle 1; hold_o high for one cycle.
- vl 0 and vl 100 -> vl 0: done_o in cycle 1, no traffic; vl 100: clamped to 4 beats.
- rst_n low during WAIT_R of beat 2 -> all outputs return to reset values; a stray rvalid after release is ignored; the next request completes normally.
